stopper_lap_ctrl: RTL and testbench
===================================

Name: stopper_lap_ctrl

Overview:
- Control FSM for the stopwatch lap-save path.
- Turns raw active-low push-buttons into single-cycle debounced press events.
- Sequences run/pause/clear of the stopwatch counter and issues write strobes with a wrapping slot pointer to the 3-slot lap store.
- Drives the display-source select for live time versus saved laps, including a review mode.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a key level must stay stable before it is accepted. Must be ≥1.
- NUM_SLOTS, 3: number of lap slots. Range 1..3.
- SCROLL_CYCLES, 50000000: review auto-scroll period. Used only with the optional feature.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- KEY  in  2  raw push-buttons, active-low, asynchronous. KEY[1] = start/stop, KEY[0] = lap/clear/step.
- active  in  1  stopwatch mode selected; when 0, press events are discarded.
- run  out  1  count enable to the stopwatch counter.
- clear  out  1  one-cycle pulse: zero the counter and the lap store.
- save_we  out  1  one-cycle pulse: write current time into slot save_slot.
- save_slot  out  2  slot index for save_we, 0..NUM_SLOTS-1.
- laps_valid  out  3  bit i set when slot i holds a lap.
- disp_sel  out  2  display source: 0 = live time, 1..3 = slot 0..2.
- state  out  2  FSM state, for debug LEDs.

Behaviour:
- Reset (RST=1 at a CLK edge, any state): all outputs 0, slot pointer 0, debounce counters 0, accepted key levels 1 (released). Reset mid-debounce or mid-review is fully cancelled.
- Key path, per key:
  - 2-FF synchroniser.
  - Counter restarts on any change of the synchronised level.
  - Level is accepted after DEBOUNCE_CYCLES stable cycles.
  - A press event is an accepted 1→0 transition: exactly one cycle, 3 + DEBOUNCE_CYCLES cycles after a clean edge. Release generates no event.
  - Events that occur while active=0 are dropped, not queued.
- FSM states: IDLE=0, RUN=1, PAUSED=2, REVIEW=3. Transitions are evaluated on press events only. p1 = KEY[1] press, p0 = KEY[0] press.
  - IDLE: run=0, disp_sel=0.
    - p1 alone → RUN.
    - p0 alone → ignored.
    - p0 and p1 in the same cycle → REVIEW, but only if laps_valid≠0; otherwise ignored.
  - RUN: run=1, disp_sel=0.
    - p0 → save_we=1 for 1 cycle with save_slot=pointer; laps_valid[pointer] set; pointer increments and wraps from NUM_SLOTS-1 to 0. On wrap the oldest slot is overwritten.
    - p1 → PAUSED.
    - p0 and p1 together → save, then PAUSED, in the same cycle.
  - PAUSED: run=0, disp_sel=0.
    - p1 → RUN.
    - p0 → clear=1 for 1 cycle; pointer=0; laps_valid=0; → IDLE.
    - p0 and p1 together → REVIEW if laps_valid≠0, else ignored.
  - REVIEW: run=0.
    - On entry, disp_sel = lowest valid slot + 1.
    - p0 → advance disp_sel to the next valid slot, wrapping over the valid set.
    - p1 → IDLE, disp_sel=0.
- Register timing: save_we, save_slot, clear, run and disp_sel are registered. They change on the edge after the press event, so latency is 1 cycle from the event.
- save_slot holds its last value when save_we=0.

Optional Feature:
- Macro STOPPER_REVIEW_AUTOSCROLL_EN.
- Defined: in REVIEW a cycle counter advances disp_sel to the next valid slot every SCROLL_CYCLES cycles. A manual p0 step also restarts that counter. The counter is cleared on REVIEW entry and exit.
- Undefined: no scroll counter is built; disp_sel changes only on p0.

Decomposition:
- Package stopper_pkg holds:
  - the state encoding constants S_IDLE/S_RUN/S_PAUSED/S_REVIEW;
  - SLOT_W=2;
  - DISP_LIVE=0;
  - a next-valid-slot function shared by the manual step and the auto-scroll.
- One sub-module, key_debounce (synchroniser, stability counter, press pulse; parameter DEBOUNCE_CYCLES), instantiated once per KEY bit.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, SCROLL_CYCLES=8, active=1 unless stated.
1. KEY[1] low for 10 cycles from IDLE → run=1 at cycle 8 after the edge (3 + 4 + 1), state=1; a 2-cycle glitch on KEY[1] → no event, state stays 0.
2. In RUN, four clean KEY[0] presses → save_we pulses with save_slot 0,1,2,0; laps_valid goes 001, 011, 111, 111.
3. RUN → p1 → PAUSED (run=0) → p0 → one-cycle clear=1, laps_valid=000, state=0. RST asserted mid-debounce of KEY[0] → no event afterwards.
4. laps_valid=101, PAUSED, both keys pressed together → REVIEW with disp_sel=1; p0 → disp_sel=3; p0 → 1; p1 → IDLE with disp_sel=0.
5. active=0 during a KEY[1] press in IDLE → state stays 0 and run stays 0. With STOPPER_REVIEW_AUTOSCROLL_EN and laps_valid=111 in REVIEW → disp_sel steps 1→2→3→1 every 8 cycles.

Source files
------------

// File: rtl/stopper_pkg.sv
// rtl/stopper_pkg.sv - shared state encoding, widths and slot-walk helper for the stopwatch lap control
package stopper_pkg;

  localparam int SLOT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_REVIEW = 2'd3
  } state_t;

  localparam logic [SLOT_W-1:0] DISP_LIVE = '0;

  // Returns the display code (slot+1) of the next valid slot after disp, wrapping
  // over slots 0..2; from DISP_LIVE this yields the lowest valid slot.
  function automatic logic [SLOT_W-1:0] next_valid_disp(input logic [2:0]        valid,
                                                        input logic [SLOT_W-1:0] disp);
    logic [SLOT_W-1:0] res;
    logic [1:0]        idx;
    res = disp;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(disp) + k - 1) % 3);
      if (valid[idx]) res = SLOT_W'(int'(idx) + 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - active-low key synchroniser and debouncer producing a one-cycle press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_last;
  logic             r_acc;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_last  <= 1'b1;
      r_acc   <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_last) begin
        r_last <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
        r_cnt <= r_cnt + CNT_W'(1);
        // Counter saturates, so acceptance happens once per stable level.
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_acc   <= r_last;
          r_press <= r_acc & ~r_last;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopper_lap_ctrl.sv
// rtl/stopper_lap_ctrl.sv - stopwatch run/lap/review FSM; STOPPER_REVIEW_AUTOSCROLL_EN adds review auto-scroll
module stopper_lap_ctrl
  import stopper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_SLOTS       = 3,
  parameter int SCROLL_CYCLES   = 50000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        KEY,
  input  logic              active,
  output logic              run,
  output logic              clear,
  output logic              save_we,
  output logic [SLOT_W-1:0] save_slot,
  output logic [2:0]        laps_valid,
  output logic [1:0]        disp_sel,
  output logic [1:0]        state
);

  if (DEBOUNCE_CYCLES < 1 || NUM_SLOTS < 1 || NUM_SLOTS > 3 || SCROLL_CYCLES < 1) begin : g_param_err
    $error("stopper_lap_ctrl: parameter out of range");
  end

  logic w_press0;
  logic w_press1;
  logic w_p0;
  logic w_p1;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .i_clk(CLK), .i_rst(RST), .i_key_n(KEY[0]), .o_press(w_press0)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .i_clk(CLK), .i_rst(RST), .i_key_n(KEY[1]), .o_press(w_press1)
  );

  assign w_p0 = w_press0 & active;
  assign w_p1 = w_press1 & active;

  state_t            r_state,      w_state_nxt;
  logic              r_run,        w_run_nxt;
  logic              r_clear,      w_clear_nxt;
  logic              r_save_we,    w_save_we_nxt;
  logic [SLOT_W-1:0] r_save_slot,  w_save_slot_nxt;
  logic [SLOT_W-1:0] r_ptr,        w_ptr_nxt;
  logic [2:0]        r_laps_valid, w_laps_nxt;
  logic [SLOT_W-1:0] r_disp_sel,   w_disp_nxt;
`ifdef STOPPER_REVIEW_AUTOSCROLL_EN
  logic [31:0]       r_scroll_cnt, w_scroll_nxt;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_clear_nxt     = 1'b0;
    w_save_we_nxt   = 1'b0;
    w_save_slot_nxt = r_save_slot;
    w_ptr_nxt       = r_ptr;
    w_laps_nxt      = r_laps_valid;
    w_disp_nxt      = r_disp_sel;
`ifdef STOPPER_REVIEW_AUTOSCROLL_EN
    w_scroll_nxt    = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_p0 && w_p1) begin
          if (|r_laps_valid) begin
            w_state_nxt = S_REVIEW;
            w_disp_nxt  = next_valid_disp(r_laps_valid, DISP_LIVE);
          end
        end else if (w_p1) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_p0) begin
          w_save_we_nxt   = 1'b1;
          w_save_slot_nxt = r_ptr;
          w_laps_nxt      = r_laps_valid | (3'b001 << r_ptr);
          w_ptr_nxt       = (r_ptr == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_ptr + SLOT_W'(1);
        end
        if (w_p1) w_state_nxt = S_PAUSED;
      end
      S_PAUSED: begin
        if (w_p0 && w_p1) begin
          if (|r_laps_valid) begin
            w_state_nxt = S_REVIEW;
            w_disp_nxt  = next_valid_disp(r_laps_valid, DISP_LIVE);
          end
        end else if (w_p1) begin
          w_state_nxt = S_RUN;
        end else if (w_p0) begin
          w_clear_nxt = 1'b1;
          w_ptr_nxt   = '0;
          w_laps_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_REVIEW: begin
        if (w_p1) begin
          w_state_nxt = S_IDLE;
          w_disp_nxt  = DISP_LIVE;
        end else if (w_p0) begin
          w_disp_nxt = next_valid_disp(r_laps_valid, r_disp_sel);
        end else begin
`ifdef STOPPER_REVIEW_AUTOSCROLL_EN
          if (r_scroll_cnt == 32'(SCROLL_CYCLES - 1)) begin
            w_disp_nxt = next_valid_disp(r_laps_valid, r_disp_sel);
          end else begin
            w_scroll_nxt = r_scroll_cnt + 32'd1;
          end
`else
          // Without auto-scroll the shown slot moves only on a manual step.
          w_disp_nxt = r_disp_sel;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_run_nxt = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_run        <= 1'b0;
      r_clear      <= 1'b0;
      r_save_we    <= 1'b0;
      r_save_slot  <= '0;
      r_ptr        <= '0;
      r_laps_valid <= '0;
      r_disp_sel   <= DISP_LIVE;
    end else begin
      r_state      <= w_state_nxt;
      r_run        <= w_run_nxt;
      r_clear      <= w_clear_nxt;
      r_save_we    <= w_save_we_nxt;
      r_save_slot  <= w_save_slot_nxt;
      r_ptr        <= w_ptr_nxt;
      r_laps_valid <= w_laps_nxt;
      r_disp_sel   <= w_disp_nxt;
    end
  end

`ifdef STOPPER_REVIEW_AUTOSCROLL_EN
  always_ff @(posedge CLK) begin
    if (RST) r_scroll_cnt <= '0;
    else     r_scroll_cnt <= w_scroll_nxt;
  end
`endif

  assign run        = r_run;
  assign clear      = r_clear;
  assign save_we    = r_save_we;
  assign save_slot  = r_save_slot;
  assign laps_valid = r_laps_valid;
  assign disp_sel   = r_disp_sel;
  assign state      = r_state;

endmodule

// File: tb/tb_stopper_lap_ctrl.sv
// tb/tb_stopper_lap_ctrl.sv - directed self-checking bench for stopper_lap_ctrl
module tb_stopper_lap_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] KEY;
  logic       active;
  logic       run;
  logic       clear;
  logic       save_we;
  logic [1:0] save_slot;
  logic [2:0] laps_valid;
  logic [1:0] disp_sel;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  stopper_lap_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .NUM_SLOTS(3),
    .SCROLL_CYCLES(8)
  ) dut (
    .CLK(CLK), .RST(RST), .KEY(KEY), .active(active),
    .run(run), .clear(clear), .save_we(save_we), .save_slot(save_slot),
    .laps_valid(laps_valid), .disp_sel(disp_sel), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Holds the masked keys low long enough for the press event to reach the outputs.
  task automatic push(input logic [1:0] mask);
    KEY = ~mask;
    tick(8);
  endtask

  task automatic rel();
    KEY = 2'b11;
    tick(12);
  endtask

  initial begin
    RST    = 1'b1;
    KEY    = 2'b11;
    active = 1'b1;
    tick(3);
    chk("rst_run",   32'(run), 0);
    chk("rst_clear", 32'(clear), 0);
    chk("rst_we",    32'(save_we), 0);
    chk("rst_slot",  32'(save_slot), 0);
    chk("rst_laps",  32'(laps_valid), 0);
    chk("rst_disp",  32'(disp_sel), 0);
    chk("rst_state", 32'(state), 0);
    RST = 1'b0;
    tick(2);

    // Glitch shorter than the debounce window
    KEY = 2'b01;
    tick(2);
    KEY = 2'b11;
    tick(12);
    chk("glitch_state", 32'(state), 0);
    chk("glitch_run",   32'(run), 0);

    // Start latency: run rises 8 cycles after the key edge
    KEY = 2'b01;
    tick(7);
    chk("start_run_c7", 32'(run), 0);
    tick(1);
    chk("start_run_c8", 32'(run), 1);
    chk("start_state",  32'(state), 1);
    rel();

    // Four laps in RUN: pointer wraps and overwrites slot 0
    push(2'b01);
    chk("lap1_we", 32'(save_we), 1); chk("lap1_slot", 32'(save_slot), 0); chk("lap1_laps", 32'(laps_valid), 1);
    tick(1); chk("lap1_we_off", 32'(save_we), 0); rel();
    push(2'b01);
    chk("lap2_we", 32'(save_we), 1); chk("lap2_slot", 32'(save_slot), 1); chk("lap2_laps", 32'(laps_valid), 3);
    tick(1); chk("lap2_we_off", 32'(save_we), 0); rel();
    push(2'b01);
    chk("lap3_we", 32'(save_we), 1); chk("lap3_slot", 32'(save_slot), 2); chk("lap3_laps", 32'(laps_valid), 7);
    tick(1); chk("lap3_we_off", 32'(save_we), 0); rel();
    push(2'b01);
    chk("lap4_we", 32'(save_we), 1); chk("lap4_slot", 32'(save_slot), 0); chk("lap4_laps", 32'(laps_valid), 7);
    tick(1); chk("lap4_we_off", 32'(save_we), 0);
    chk("lap4_slot_hold", 32'(save_slot), 0);
    chk("lap4_state", 32'(state), 1);
    rel();

    // Pause, then clear
    push(2'b10);
    chk("pause_state", 32'(state), 2);
    chk("pause_run",   32'(run), 0);
    rel();
    push(2'b01);
    chk("clr_pulse", 32'(clear), 1);
    chk("clr_laps",  32'(laps_valid), 0);
    chk("clr_state", 32'(state), 0);
    tick(1);
    chk("clr_pulse_off", 32'(clear), 0);
    rel();

    // Reset in the middle of a debounce cancels the pending press
    KEY = 2'b01;
    tick(4);
    RST = 1'b1;
    tick(1);
    KEY = 2'b11;
    tick(2);
    RST = 1'b0;
    tick(15);
    chk("rstmid_state", 32'(state), 0);
    chk("rstmid_run",   32'(run), 0);

    // Presses while inactive are dropped
    active = 1'b0;
    push(2'b10);
    rel();
    active = 1'b1;
    tick(4);
    chk("inactive_state", 32'(state), 0);
    chk("inactive_run",   32'(run), 0);

    // Both keys in IDLE with no laps: ignored
    push(2'b11);
    chk("idle_both_empty", 32'(state), 0);
    rel();

    // Build laps 011: one plain lap, then save+pause together
    push(2'b10);
    chk("run2_state", 32'(state), 1);
    rel();
    push(2'b01);
    chk("run2_lap_slot", 32'(save_slot), 0);
    rel();
    push(2'b11);
    chk("savepause_we",    32'(save_we), 1);
    chk("savepause_slot",  32'(save_slot), 1);
    chk("savepause_laps",  32'(laps_valid), 3);
    chk("savepause_state", 32'(state), 2);
    chk("savepause_run",   32'(run), 0);
    rel();

    // Enter review from PAUSED
    push(2'b11);
    chk("rev_state", 32'(state), 3);
    chk("rev_disp",  32'(disp_sel), 1);
`ifndef STOPPER_REVIEW_AUTOSCROLL_EN
    rel();
    tick(16);
    chk("rev_disp_steady", 32'(disp_sel), 1);
    push(2'b01);
    chk("rev_step1", 32'(disp_sel), 2);
    rel();
    push(2'b01);
    chk("rev_step_wrap", 32'(disp_sel), 1);
    rel();
`else
    tick(7);
    chk("scroll_hold", 32'(disp_sel), 1);
    tick(1);
    chk("scroll_1", 32'(disp_sel), 2);
    tick(8);
    chk("scroll_2", 32'(disp_sel), 1);
    rel();
`endif
    push(2'b10);
    chk("rev_exit_state", 32'(state), 0);
    chk("rev_exit_disp",  32'(disp_sel), 0);
    rel();

    // Review from IDLE with laps present
    push(2'b11);
    chk("idle_rev_state", 32'(state), 3);
    chk("idle_rev_disp",  32'(disp_sel), 1);
    chk("idle_rev_run",   32'(run), 0);
    rel();
    push(2'b10);
    chk("idle_rev_exit", 32'(state), 0);
    rel();

    // Pointer continued at slot 2 after the earlier laps
    push(2'b10);
    rel();
    push(2'b10);
    chk("repause_state", 32'(state), 2);
    rel();
    push(2'b10);
    chk("resume_run", 32'(run), 1);
    rel();
    push(2'b01);
    chk("lap_slot2", 32'(save_slot), 2);
    chk("lap_laps7", 32'(laps_valid), 7);
    rel();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
